// File: rtl/branch_history_table_pkg.sv
// Shared types and helpers for the branch history table.
//   ctr2_e    : names for the 2-bit counter states (debug / bench readability)
//   idx_width : table index width from the entry count
//   sat_inc / sat_dec : saturating step on a counter of caller-chosen width
//                       (value carried in 4 bits, width 1..4 passed in)
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr2_e;

  function automatic int idx_width(int entries);
    return (entries <= 2) ? 1 : $clog2(entries);
  endfunction

  // Saturates at 2^w-1; bits above w are expected to be zero.
  function automatic logic [3:0] sat_inc(logic [3:0] v, int w);
    int mx;
    mx = (1 << w) - 1;
    if (int'(v) >= mx) return 4'(mx);
    return v + 4'd1;
  endfunction

  // Saturates at 0.
  function automatic logic [3:0] sat_dec(logic [3:0] v, int w);
    if (v == 4'd0 || w == 0) return 4'd0;
    return v - 4'd1;
  endfunction

endpackage

// File: rtl/branch_history_table_if.sv
// Fetch/execute-side bus of the branch history table.
//   pred_req/pred_pc            : prediction request from fetch
//   pred_valid/taken/ctr/index  : registered prediction response
//   upd_valid/upd_index/upd_taken : resolved-branch update from execute
//   ghr                         : current global history (observability)
// master = requester (fetch/execute side), slave = the table.
interface branch_history_table_if #(
  parameter int PC_WIDTH  = 32,
  parameter int IW        = 6,
  parameter int CTR_WIDTH = 2,
  parameter int GW        = 1
);
  logic                 pred_req;
  logic [PC_WIDTH-1:0]  pred_pc;
  logic                 pred_valid;
  logic                 pred_taken;
  logic [CTR_WIDTH-1:0] pred_ctr;
  logic [IW-1:0]        pred_index;
  logic                 upd_valid;
  logic [IW-1:0]        upd_index;
  logic                 upd_taken;
  logic [GW-1:0]        ghr;

  modport master (
    output pred_req, pred_pc, upd_valid, upd_index, upd_taken,
    input  pred_valid, pred_taken, pred_ctr, pred_index, ghr
  );

  modport slave (
    input  pred_req, pred_pc, upd_valid, upd_index, upd_taken,
    output pred_valid, pred_taken, pred_ctr, pred_index, ghr
  );
endinterface

// File: rtl/branch_history_table_sat_counter.sv
// Combinational next state of one saturating direction counter.
//   ctr      : current counter value
//   taken    : resolved outcome
//   ctr_next : ctr+1 on taken, ctr-1 otherwise, clamped at both ends
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] ctr_next
);

  logic [3:0] ctr_ext;

  always_comb begin
    ctr_ext = 4'(ctr);
    if (taken) ctr_next = CTR_WIDTH'(sat_inc(ctr_ext, CTR_WIDTH));
    else       ctr_next = CTR_WIDTH'(sat_dec(ctr_ext, CTR_WIDTH));
  end

endmodule

// File: rtl/branch_history_table.sv
// Table of ENTRIES saturating direction counters (bimodal, or gshare when
// HIST_LEN>0). One registered prediction and one resolved update per cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active low; clears counters, history and outputs
//   bus   : branch_history_table_if slave (prediction + update + ghr)
module branch_history_table
  import bp_pkg::*;
#(
  parameter int ENTRIES   = 64,
  parameter int CTR_WIDTH = 2,
  parameter int PC_WIDTH  = 32,
  parameter int INDEX_LSB = 2,
  parameter int HIST_LEN  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_history_table_if.slave bus
);

  localparam int IW = idx_width(ENTRIES);
  localparam int GW = (HIST_LEN > 0) ? HIST_LEN : 1;

  // Flop array rather than RAM: every entry must clear on reset.
  logic [CTR_WIDTH-1:0] tbl_q [ENTRIES];
  logic [CTR_WIDTH-1:0] tbl_d [ENTRIES];
  logic [GW-1:0]        ghr_q, ghr_d;

  logic                 pred_valid_q, pred_valid_d;
  logic                 pred_taken_q, pred_taken_d;
  logic [CTR_WIDTH-1:0] pred_ctr_q,   pred_ctr_d;
  logic [IW-1:0]        pred_index_q, pred_index_d;

  logic [IW-1:0]        raw_idx, pidx;
  logic [CTR_WIDTH-1:0] upd_ctr, upd_next, fwd_ctr;

  // PC bits outside the index window are intentionally ignored.
  logic unused_pc;
  assign unused_pc = ^bus.pred_pc;

  // Single update-path counter; the forwarding mux reuses its result.
  assign upd_ctr = tbl_q[bus.upd_index];

  bp_sat_counter #(.CTR_WIDTH(CTR_WIDTH)) u_sat (
    .ctr      (upd_ctr),
    .taken    (bus.upd_taken),
    .ctr_next (upd_next)
  );

  // Index hashing uses the history as it stood before this cycle's update.
  always_comb begin
    raw_idx = bus.pred_pc[INDEX_LSB +: IW];
    pidx    = raw_idx;
    if (HIST_LEN > 0) pidx = raw_idx ^ IW'(ghr_q);
  end

  // A same-cycle update to the predicted entry is forwarded so the
  // prediction never sees a stale counter.
  always_comb begin
    fwd_ctr = tbl_q[pidx];
    if (bus.upd_valid && (bus.upd_index == pidx)) fwd_ctr = upd_next;
  end

  always_comb begin
    tbl_d = tbl_q;
    if (bus.upd_valid) tbl_d[bus.upd_index] = upd_next;
  end

  // History is non-speculative: shifted only on resolved updates.
  // Truncating {ghr, taken} to GW bits drops the oldest outcome.
  always_comb begin
    ghr_d = ghr_q;
    if (HIST_LEN == 0)      ghr_d = '0;
    else if (bus.upd_valid) ghr_d = GW'({ghr_q, bus.upd_taken});
  end

  // Response fields hold their last value while no request is made.
  always_comb begin
    pred_valid_d = bus.pred_req;
    pred_taken_d = pred_taken_q;
    pred_ctr_d   = pred_ctr_q;
    pred_index_d = pred_index_q;
    if (bus.pred_req) begin
      pred_ctr_d   = fwd_ctr;
      pred_taken_d = fwd_ctr[CTR_WIDTH-1];
      pred_index_d = pidx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ctr_q   <= '0;
      pred_index_q <= '0;
    end else begin
      tbl_q        <= tbl_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_ctr_q   <= pred_ctr_d;
      pred_index_q <= pred_index_d;
    end
  end

  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.pred_ctr   = pred_ctr_q;
  assign bus.pred_index = pred_index_q;
  assign bus.ghr        = ghr_q;

endmodule

// File: tb/tb_branch_history_table.sv
// Drives three tables in lockstep from one stimulus stream:
//   d0 bimodal 2-bit, d1 gshare HIST_LEN=4, d2 bimodal 3-bit.
// A behavioural model predicts each response; expectations are queued at
// drive time and popped when the response is due.
module tb_branch_history_table;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req, uvld, utk;
  logic [31:0] pc;
  logic [5:0]  uidx;

  branch_history_table_if #(.PC_WIDTH(32), .IW(6), .CTR_WIDTH(2), .GW(1)) if_a ();
  branch_history_table_if #(.PC_WIDTH(32), .IW(6), .CTR_WIDTH(2), .GW(4)) if_b ();
  branch_history_table_if #(.PC_WIDTH(32), .IW(6), .CTR_WIDTH(3), .GW(1)) if_c ();

  assign if_a.pred_req = req;  assign if_b.pred_req = req;  assign if_c.pred_req = req;
  assign if_a.pred_pc  = pc;   assign if_b.pred_pc  = pc;   assign if_c.pred_pc  = pc;
  assign if_a.upd_valid = uvld; assign if_b.upd_valid = uvld; assign if_c.upd_valid = uvld;
  assign if_a.upd_index = uidx; assign if_b.upd_index = uidx; assign if_c.upd_index = uidx;
  assign if_a.upd_taken = utk;  assign if_b.upd_taken = utk;  assign if_c.upd_taken = utk;

  branch_history_table #(.ENTRIES(64), .CTR_WIDTH(2), .PC_WIDTH(32), .INDEX_LSB(2), .HIST_LEN(0))
    u_a (.clk(clk), .reset(rst_n), .bus(if_a.slave));
  branch_history_table #(.ENTRIES(64), .CTR_WIDTH(2), .PC_WIDTH(32), .INDEX_LSB(2), .HIST_LEN(4))
    u_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));
  branch_history_table #(.ENTRIES(64), .CTR_WIDTH(3), .PC_WIDTH(32), .INDEX_LSB(2), .HIST_LEN(0))
    u_c (.clk(clk), .reset(rst_n), .bus(if_c.slave));

  // Gathered outputs, indexed by DUT.
  logic [2:0]      pv, pt;
  logic [2:0][3:0] po_ctr, po_ghr;
  logic [2:0][5:0] po_idx;
  assign pv = {if_c.pred_valid, if_b.pred_valid, if_a.pred_valid};
  assign pt = {if_c.pred_taken, if_b.pred_taken, if_a.pred_taken};
  assign po_ctr[0] = 4'(if_a.pred_ctr);
  assign po_ctr[1] = 4'(if_b.pred_ctr);
  assign po_ctr[2] = 4'(if_c.pred_ctr);
  assign po_idx[0] = if_a.pred_index;
  assign po_idx[1] = if_b.pred_index;
  assign po_idx[2] = if_c.pred_index;
  assign po_ghr[0] = 4'(if_a.ghr);
  assign po_ghr[1] = 4'(if_b.ghr);
  assign po_ghr[2] = 4'(if_c.ghr);

  int W [3] = '{2, 2, 3};
  int H [3] = '{0, 4, 0};
  int mctr [3][64];
  int mghr [3];

  typedef struct packed {
    logic [2:0][3:0] ctr;
    logic [2:0][5:0] idx;
  } exp_t;
  exp_t sbq [$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int nxt(int c, bit t, int w);
    if (t) return (c == (1 << w) - 1) ? c : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic int idx_of(logic [31:0] p, int h, int g);
    int i;
    i = int'(p[7:2]);
    if (h > 0) i = i ^ (g & ((1 << h) - 1));
    return i;
  endfunction

  // One cycle of stimulus; the model is advanced in the same order the
  // hardware must honour (index from old history, then update, then read).
  task automatic step(bit rq, logic [31:0] p, bit uv, logic [5:0] ui, bit ut);
    exp_t e;
    int   pi;
    @(negedge clk); #1;
    req = rq; pc = p; uvld = uv; uidx = ui; utk = ut;
    e = '0;
    for (int d = 0; d < 3; d++) begin
      pi = idx_of(p, H[d], mghr[d]);
      if (uv) begin
        mctr[d][ui] = nxt(mctr[d][ui], ut, W[d]);
        if (H[d] > 0) mghr[d] = ((mghr[d] << 1) | int'(ut)) & ((1 << H[d]) - 1);
      end
      e.idx[d] = 6'(pi);
      e.ctr[d] = 4'(mctr[d][pi]);
    end
    if (rq) sbq.push_back(e);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; req = 1'b0; uvld = 1'b0;
    sbq.delete();
    for (int d = 0; d < 3; d++) begin
      mghr[d] = 0;
      for (int i = 0; i < 64; i++) mctr[d][i] = 0;
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid%0d", d), int'(pv[d]), 0);
      chk($sformatf("rst_ctr%0d", d), int'(po_ctr[d]), 0);
      chk($sformatf("rst_idx%0d", d), int'(po_idx[d]), 0);
      chk($sformatf("rst_taken%0d", d), int'(pt[d]), 0);
      chk($sformatf("rst_ghr%0d", d), int'(po_ghr[d]), 0);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Response checker: a queued entry means a response is due this cycle,
  // otherwise valid must be low and the response fields must hold.
  logic [2:0][3:0] last_ctr;
  logic [2:0][5:0] last_idx;
  always @(negedge clk) begin
    exp_t cur;
    if (!rst_n) begin
      last_ctr = '0;
      last_idx = '0;
    end else begin
      if (sbq.size() > 0) begin
        cur = sbq.pop_front();
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("valid%0d", d), int'(pv[d]), 1);
          chk($sformatf("ctr%0d", d), int'(po_ctr[d]), int'(cur.ctr[d]));
          chk($sformatf("taken%0d", d), int'(pt[d]), int'(cur.ctr[d]) >> (W[d] - 1));
          chk($sformatf("idx%0d", d), int'(po_idx[d]), int'(cur.idx[d]));
        end
        last_ctr = cur.ctr;
        last_idx = cur.idx;
      end else begin
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("idle_valid%0d", d), int'(pv[d]), 0);
          chk($sformatf("hold_ctr%0d", d), int'(po_ctr[d]), int'(last_ctr[d]));
          chk($sformatf("hold_idx%0d", d), int'(po_idx[d]), int'(last_idx[d]));
          chk($sformatf("hold_taken%0d", d), int'(pt[d]), int'(last_ctr[d]) >> (W[d] - 1));
        end
      end
      for (int d = 0; d < 3; d++)
        chk($sformatf("ghr%0d", d), int'(po_ghr[d]), mghr[d]);
    end
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; pc = '0; uvld = 1'b0; uidx = '0; utk = 1'b0;
    for (int d = 0; d < 3; d++) begin
      mghr[d] = 0;
      for (int i = 0; i < 64; i++) mctr[d][i] = 0;
    end
    do_reset();

    // Default prediction after reset: PC 0x100 maps to index 0.
    step(1'b1, 32'h100, 1'b0, 6'd0, 1'b0);
    @(posedge clk); #2;
    chk("def_idx", int'(if_a.pred_index), 0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);

    // Saturate up then down on index 7 (PC 0x1C), predicting alongside.
    for (int k = 0; k < 5; k++) step(1'b1, 32'h1C, 1'b1, 6'd7, 1'b1);
    @(posedge clk); #2;
    chk("sat_up_a", int'(if_a.pred_ctr), int'(ST));
    for (int k = 0; k < 4; k++) step(1'b1, 32'h1C, 1'b1, 6'd7, 1'b0);
    @(posedge clk); #2;
    chk("sat_dn_a", int'(if_a.pred_ctr), int'(SNT));
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);

    // Forwarding: index 5 to 1, then update+predict same cycle.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 6'd5, 1'b1);
    step(1'b1, 32'h14, 1'b1, 6'd5, 1'b1);
    @(posedge clk); #2;
    chk("fwd_ctr_a", int'(if_a.pred_ctr), 2);
    chk("fwd_taken_a", int'(if_a.pred_taken), 1);
    step(1'b1, 32'h14, 1'b1, 6'd9, 1'b0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);

    // Gshare: T,T,NT,T gives ghr 1101; PC 0x40 hashes to 0x1D.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 6'd3, 1'b1);
    step(1'b0, 32'h0, 1'b1, 6'd3, 1'b1);
    step(1'b0, 32'h0, 1'b1, 6'd3, 1'b0);
    step(1'b0, 32'h0, 1'b1, 6'd3, 1'b1);
    step(1'b1, 32'h40, 1'b0, 6'd0, 1'b0);
    chk("gs_ghr", int'(if_b.ghr), 13);
    @(posedge clk); #2;
    chk("gs_idx", int'(if_b.pred_index), 29);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);

    // 3-bit counters: saturate at 7, then walk down across the MSB.
    do_reset();
    for (int k = 0; k < 9; k++) step(1'b1, 32'h30, 1'b1, 6'd12, 1'b1);
    @(posedge clk); #2;
    chk("w3_sat", int'(if_c.pred_ctr), 7);
    step(1'b1, 32'h30, 1'b1, 6'd12, 1'b0);
    @(posedge clk); #2;
    chk("w3_six", int'(if_c.pred_ctr), 6);
    chk("w3_six_tk", int'(if_c.pred_taken), 1);
    for (int k = 0; k < 3; k++) step(1'b1, 32'h30, 1'b1, 6'd12, 1'b0);
    @(posedge clk); #2;
    chk("w3_three", int'(if_c.pred_ctr), 3);
    chk("w3_three_tk", int'(if_c.pred_taken), 0);

    // Reset mid-operation with a response in flight.
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, 6'd20, 1'b1);
    step(1'b1, 32'h50, 1'b0, 6'd0, 1'b0);
    do_reset();
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    step(1'b1, 32'h50, 1'b0, 6'd0, 1'b0);
    @(posedge clk); #2;
    chk("post_rst_ctr", int'(if_a.pred_ctr), 0);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
    @(negedge clk); #2;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
